clk_ratio_ctrl: RTL

CLK_RATIO_CTRL -- requirements
Module: clk_ratio_ctrl

---
 rtl/clk_ratio_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clk_ratio_ctrl.sv
// clk_ratio_ctrl: programmable clock-ratio divider with handshaked ratio updates.
// Ratio changes are deferred to a period boundary so that no period is ever
// truncated or stretched. tick marks the last cycle of each period; div_clk is
// high for the first ceil(N/2) cycles of each period.
module clk_ratio_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         tick,
  output logic         div_clk,
  output logic [W-1:0] active_div,
  output logic [1:0]   state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;

  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] active_div_q, active_div_d;
  logic         pend_valid_q, pend_valid_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         cfg_err_q, cfg_err_d;

  logic         running;
  logic         boundary;
  logic         cfg_accept;
  logic [W-1:0] high_len;

  // Decode period position and handshake qualifiers from registered state only.
  always_comb begin
    running    = (state_q == RUN) || (state_q == DRAIN);
    boundary   = running && (cnt_q == (active_div_q - W'(1)));
    cfg_accept = cfg_valid && !pend_valid_q;
    high_len   = (active_div_q >> 1) + {{(W-1){1'b0}}, active_div_q[0]};
  end

  // Next-state logic: counter, ratio/pending registers and FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_div_d = active_div_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    cfg_err_d    = 1'b0;

    // Boundary update runs first; a handshake can only occur with no pending
    // ratio, so one landing on the boundary is queued for the next boundary.
    if (running) begin
      if (boundary) begin
        cnt_d = '0;
        if (pend_valid_q) begin
          active_div_d = pend_div_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (cfg_accept) begin
      if (cfg_div == '0) begin
        cfg_err_d = 1'b1;
      end else if (!running) begin
        active_div_d = cfg_div;
      end else begin
        pend_valid_d = 1'b1;
        pend_div_d   = cfg_div;
      end
    end

    case (state_q)
      IDLE:    state_d = run ? RUN : IDLE;
      RUN:     state_d = run ? RUN : (boundary ? IDLE : DRAIN);
      DRAIN:   state_d = run ? RUN : (boundary ? IDLE : DRAIN);
      default: state_d = IDLE;
    endcase
  end

  // Registered state with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      active_div_q <= DEF_DIV_W;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Outputs decoded from registered state and counter only.
  always_comb begin
    cfg_ready  = !pend_valid_q;
    cfg_err    = cfg_err_q;
    tick       = boundary;
    div_clk    = running && (cnt_q < high_len);
    active_div = active_div_q;
    state      = state_q;
  end

endmodule
